// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with double-buffered period/duty/mode, transferred at period boundaries.
// Define PWM_CENTER_MODE_EN to build in center-aligned (up/down) counting selected by mode=1.
module pwm_multi_ch #(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [WIDTH-1:0]        period,
    input  logic [NUM_CH*WIDTH-1:0] duty,
    input  logic                    mode,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_tick,
    output logic                    pending
);

    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);

    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        stg_per_q, stg_per_d, sh_per_q, sh_per_d;
    logic [NUM_CH*WIDTH-1:0] stg_duty_q, stg_duty_d, sh_duty_q, sh_duty_d;
    logic [NUM_CH-1:0]       pwm_q, pwm_d;
    logic                    tick_q, tick_d;
    logic                    pend_q, pend_d;
    logic [WIDTH-1:0]        per_m1;
    logic                    boundary;
    logic                    xfer;

`ifdef PWM_CENTER_MODE_EN
    logic stg_mode_q, stg_mode_d, sh_mode_q, sh_mode_d;
    logic dir_q, dir_d;  // 1 = counting down
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_comb begin
        per_m1   = sh_per_q - 1'b1;
        boundary = 1'b0;
        cnt_d    = '0;
`ifdef PWM_CENTER_MODE_EN
        dir_d    = 1'b0;
`endif
        if (sh_per_q <= WIDTH'(1)) begin
            boundary = 1'b1;
`ifdef PWM_CENTER_MODE_EN
        end else if (sh_mode_q) begin
            if (dir_q) begin
                if (cnt_q <= WIDTH'(1)) begin
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = 1'b1;
                end
            end else if (cnt_q >= per_m1) begin
                // Ps==2 has no room to turn around: the top is also the boundary
                if (per_m1 <= WIDTH'(1)) begin
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
        end else if (cnt_q >= per_m1) begin
            boundary = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!enable) begin
            boundary = 1'b0;
            cnt_d    = '0;
`ifdef PWM_CENTER_MODE_EN
            dir_d    = 1'b0;
`endif
        end

        tick_d = boundary;
        // A load on the transfer cycle wins: the old staged set is dropped
        xfer   = pend_q && !load && (boundary || !enable);

        stg_per_d  = stg_per_q;
        stg_duty_d = stg_duty_q;
        sh_per_d   = sh_per_q;
        sh_duty_d  = sh_duty_q;
        pend_d     = pend_q;
`ifdef PWM_CENTER_MODE_EN
        stg_mode_d = stg_mode_q;
        sh_mode_d  = sh_mode_q;
`endif
        if (load) begin
            stg_per_d  = period;
            stg_duty_d = duty;
            pend_d     = 1'b1;
`ifdef PWM_CENTER_MODE_EN
            stg_mode_d = mode;
`endif
        end else if (xfer) begin
            sh_per_d  = stg_per_q;
            sh_duty_d = stg_duty_q;
            pend_d    = 1'b0;
`ifdef PWM_CENTER_MODE_EN
            sh_mode_d = stg_mode_q;
`endif
        end

        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = enable && (cnt_q < sh_duty_q[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            stg_per_q  <= DEF_P;
            stg_duty_q <= '0;
            sh_per_q   <= DEF_P;
            sh_duty_q  <= '0;
            pwm_q      <= '0;
            tick_q     <= 1'b0;
            pend_q     <= 1'b0;
`ifdef PWM_CENTER_MODE_EN
            stg_mode_q <= 1'b0;
            sh_mode_q  <= 1'b0;
            dir_q      <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            stg_per_q  <= stg_per_d;
            stg_duty_q <= stg_duty_d;
            sh_per_q   <= sh_per_d;
            sh_duty_q  <= sh_duty_d;
            pwm_q      <= pwm_d;
            tick_q     <= tick_d;
            pend_q     <= pend_d;
`ifdef PWM_CENTER_MODE_EN
            stg_mode_q <= stg_mode_d;
            sh_mode_q  <= sh_mode_d;
            dir_q      <= dir_d;
`endif
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign pending     = pend_q;

endmodule
